// File: rtl/autoteste_and.sv
// Built-in self-test for an AND gate: sweeps every operand pair, compares the
// gate output against the expected AND and reports errors and the first failing vector.
module autoteste_and #(
  parameter int LARGURA       = 1,
  parameter int LARGURA_ERROS = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     iniciar,
  output logic [LARGURA-1:0]       Entrada1,
  output logic [LARGURA-1:0]       Entrada2,
  input  logic [LARGURA-1:0]       Resultado,
  output logic                     ocupado,
  output logic                     concluido,
  output logic                     aprovado,
  output logic [LARGURA_ERROS-1:0] erros,
  output logic [LARGURA-1:0]       falha_e1,
  output logic [LARGURA-1:0]       falha_e2
);

  localparam int KW = 2 * LARGURA;
  localparam logic [KW-1:0]            K_ULTIMO  = '1;
  localparam logic [KW-1:0]            K_UM      = KW'(1);
  localparam logic [LARGURA_ERROS-1:0] ERROS_MAX = '1;
  localparam logic [LARGURA_ERROS-1:0] ERROS_UM  = LARGURA_ERROS'(1);

  typedef enum logic [1:0] {OCIOSO, APLICA, AMOSTRA, FIM} estado_t;

  estado_t       estado;
  logic [KW-1:0] k;
  logic          divergente;

  // The operands come straight from the index register; k is parked at 0
  // outside a sweep so the gate inputs rest at 0.
  assign Entrada1   = k[KW-1:LARGURA];
  assign Entrada2   = k[LARGURA-1:0];
  assign divergente = (Resultado != (Entrada1 & Entrada2));

  always_ff @(posedge clock) begin
    if (reset) begin
      estado    <= OCIOSO;
      k         <= '0;
      ocupado   <= 1'b0;
      concluido <= 1'b0;
      aprovado  <= 1'b0;
      erros     <= '0;
      falha_e1  <= '0;
      falha_e2  <= '0;
    end else begin
      case (estado)
        OCIOSO, FIM: begin
          if (iniciar) begin
            estado    <= APLICA;
            k         <= '0;
            ocupado   <= 1'b1;
            concluido <= 1'b0;
            aprovado  <= 1'b0;
            erros     <= '0;
            falha_e1  <= '0;
            falha_e2  <= '0;
          end
        end
        APLICA: begin
          estado <= AMOSTRA;
        end
        AMOSTRA: begin
          if (divergente) begin
            if (erros != ERROS_MAX) erros <= erros + ERROS_UM;
            if (erros == '0) begin
              falha_e1 <= Entrada1;
              falha_e2 <= Entrada2;
            end
          end
          // The sweep ends on the last index; k is never allowed to wrap.
          if (k == K_ULTIMO) begin
            estado    <= FIM;
            k         <= '0;
            ocupado   <= 1'b0;
            concluido <= 1'b1;
            aprovado  <= (erros == '0) && !divergente;
          end else begin
            estado <= APLICA;
            k      <= k + K_UM;
          end
        end
        default: begin
          estado <= OCIOSO;
        end
      endcase
    end
  end

endmodule
